// File: rtl/im_frame_sync.sv
// Frame-synchronous location update scheduler for the Pong renderer.
// CPU writes land in pending registers and are copied to the active set at the start of vblank.
module im_frame_sync #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LOC_W    = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wr_data,
  output logic [31:0] ball_loc,
  output logic [31:0] barl_loc,
  output logic [31:0] barr_loc,
  output logic [15:0] frame_cnt,
  output logic        vblank_irq,
  output logic        armed,
  output logic        overrun,
  input  logic        ovr_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [9:0]       r_prev_y;
  logic [15:0]      r_frame_cnt;
  logic             r_irq;
  logic             r_dirty;
  logic             r_overrun;
  logic [LOC_W-1:0] r_pend_ball;
  logic [LOC_W-1:0] r_pend_barl;
  logic [LOC_W-1:0] r_pend_barr;
  logic [LOC_W-1:0] r_act_ball;
  logic [LOC_W-1:0] r_act_barl;
  logic [LOC_W-1:0] r_act_barr;
  logic             w_vb_edge;
  logic             w_xfer;
  logic             w_commit;
  logic             w_ovr_set;
  logic             w_unused;

  assign w_vb_edge = (pixel_y == 10'(V_ACTIVE)) && (r_prev_y != 10'(V_ACTIVE));
  // Ready is gated by rst_n so the CPU never sees a handshake while the block is held in reset.
  assign wr_ready  = rst_n && (r_state == IDLE);
  assign w_xfer    = wr_valid && wr_ready;
  assign w_unused  = ^{pixel_x, wr_data[31:LOC_W], 10'(H_ACTIVE)};

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      IDLE: begin
        // A commit accepted on the vblank edge itself defers to the next frame and suppresses overrun.
        if (w_xfer && (wr_sel == 2'd3)) begin
          w_state_nxt = ARMED;
        end else begin
          w_state_nxt = IDLE;
          w_ovr_set   = w_vb_edge && r_dirty;
        end
      end
      ARMED: begin
        if (w_vb_edge) begin
          w_state_nxt = COMMIT;
        end else begin
          w_state_nxt = ARMED;
        end
      end
      COMMIT: begin
        w_state_nxt = IDLE;
        w_commit    = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_y    <= 10'd0;
      r_frame_cnt <= 16'd0;
      r_irq       <= 1'b0;
    end else begin
      r_prev_y    <= pixel_y;
      r_irq       <= w_vb_edge;
      r_frame_cnt <= w_vb_edge ? (r_frame_cnt + 16'd1) : r_frame_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_ball <= '0;
      r_pend_barl <= '0;
      r_pend_barr <= '0;
    end else if (w_xfer) begin
      case (wr_sel)
        2'd0:    r_pend_ball <= wr_data[LOC_W-1:0];
        2'd1:    r_pend_barl <= wr_data[LOC_W-1:0];
        2'd2:    r_pend_barr <= wr_data[LOC_W-1:0];
        default: r_pend_ball <= r_pend_ball;
      endcase
    end else begin
      r_pend_ball <= r_pend_ball;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dirty <= 1'b0;
    end else if (w_commit) begin
      r_dirty <= 1'b0;
    end else if (w_xfer && (wr_sel != 2'd3)) begin
      r_dirty <= 1'b1;
    end else begin
      r_dirty <= r_dirty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_ball <= '0;
      r_act_barl <= '0;
      r_act_barr <= '0;
    end else if (w_commit) begin
      r_act_ball <= r_pend_ball;
      r_act_barl <= r_pend_barl;
      r_act_barr <= r_pend_barr;
    end else begin
      r_act_ball <= r_act_ball;
    end
  end

  // Set has priority over clear so a same-cycle overrun is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign ball_loc   = 32'(r_act_ball);
  assign barl_loc   = 32'(r_act_barl);
  assign barr_loc   = 32'(r_act_barr);
  assign frame_cnt  = r_frame_cnt;
  assign vblank_irq = r_irq;
  assign armed      = (r_state != IDLE);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_im_frame_sync.sv
// Scoreboard bench for im_frame_sync: each frame pushes an expected record,
// a negedge monitor pops it on every vblank_irq and checks N+1 / N+2 values.
module tb_im_frame_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic [31:0] ball_loc;
  logic [31:0] barl_loc;
  logic [31:0] barr_loc;
  logic [15:0] frame_cnt;
  logic        vblank_irq;
  logic        armed;
  logic        overrun;
  logic        ovr_clr;

  typedef struct {
    logic [15:0] cnt;
    logic [31:0] pre_b, pre_l, pre_r;
    logic [31:0] post_b, post_l, post_r;
    logic        post_armed;
    logic        post_ovr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_rec;
  int          total = 0;
  int          bad = 0;
  int          mon_phase = 0;
  logic [9:0]  last_y = 10'd0;
  logic [31:0] cur_b = 32'd0, cur_l = 32'd0, cur_r = 32'd0;

  im_frame_sync dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
    .ball_loc(ball_loc), .barl_loc(barl_loc), .barr_loc(barr_loc),
    .frame_cnt(frame_cnt), .vblank_irq(vblank_irq), .armed(armed),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: irq cycle is N+1 (pre-commit values), the following cycle is N+2.
  always @(negedge clk) begin
    if (mon_phase == 1) begin
      chk("post_ball", ball_loc, mon_rec.post_b);
      chk("post_barl", barl_loc, mon_rec.post_l);
      chk("post_barr", barr_loc, mon_rec.post_r);
      chk("post_armed", {31'd0, armed}, {31'd0, mon_rec.post_armed});
      chk("post_overrun", {31'd0, overrun}, {31'd0, mon_rec.post_ovr});
      chk("irq_width", {31'd0, vblank_irq}, 32'd0);
      mon_phase = 0;
    end else if (vblank_irq === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_irq", 32'd1, 32'd0);
      end else begin
        mon_rec = sb_q.pop_front();
        chk("irq_timing_y", {22'd0, last_y}, 32'd480);
        chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, mon_rec.cnt});
        chk("pre_ball", ball_loc, mon_rec.pre_b);
        chk("pre_barl", barl_loc, mon_rec.pre_l);
        chk("pre_barr", barr_loc, mon_rec.pre_r);
        mon_phase = 1;
      end
    end else begin
      mon_phase = 0;
    end
    last_y = pixel_y;
  end

  task automatic wr(input logic [1:0] sel, input logic [31:0] data, input logic exp_rdy);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = data;
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, exp_rdy});
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic frame(input logic [15:0] cnt, input logic [31:0] b, input logic [31:0] l,
                       input logic [31:0] r, input logic arm, input logic ovr,
                       input logic clr_n, input logic commit_n);
    exp_t e;
    e.cnt = cnt;
    e.pre_b = cur_b; e.pre_l = cur_l; e.pre_r = cur_r;
    e.post_b = b; e.post_l = l; e.post_r = r;
    e.post_armed = arm;
    e.post_ovr = ovr;
    sb_q.push_back(e);
    cur_b = b; cur_l = l; cur_r = r;
    pixel_y = 10'd479;
    tick();
    pixel_y = 10'd480;
    ovr_clr = clr_n;
    if (commit_n) begin
      wr_valid = 1'b1;
      wr_sel   = 2'd3;
    end
    tick();
    ovr_clr = 1'b0;
    if (commit_n) wr_valid = 1'b0;
    pixel_y = 10'd481;
    tick();
    pixel_y = 10'd482;
    tick();
    pixel_y = 10'd0;
    tick();
  endtask

  task automatic clr_pulse();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0;
    wr_valid = 1'b0; wr_sel = 2'd0; wr_data = 32'd0; ovr_clr = 1'b0;
    #12;
    chk("rst_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_ball", ball_loc, 32'd0);
    chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    frame(16'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(16'd2, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    wr(2'd0, 32'h0003C140, 1'b1);
    wr(2'd1, 32'hFFF32C0A, 1'b1);
    wr(2'd3, 32'd0, 1'b1);
    chk("armed_set", {31'd0, armed}, 32'd1);
    chk("ball_hold", ball_loc, 32'd0);
    frame(16'd3, 32'h0003C140, 32'h00032C0A, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Writes stall while armed, then land once the commit completes.
    wr(2'd3, 32'd0, 1'b1);
    wr_valid = 1'b1; wr_sel = 2'd0; wr_data = 32'h00011111;
    tick();
    chk("armed_stall", {31'd0, wr_ready}, 32'd0);
    frame(16'd4, 32'h0003C140, 32'h00032C0A, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ready_back", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b0;
    frame(16'd5, 32'h0003C140, 32'h00032C0A, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    clr_pulse();

    wr(2'd2, 32'h00012345, 1'b1);
    frame(16'd6, 32'h0003C140, 32'h00032C0A, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    clr_pulse();
    frame(16'd7, 32'h0003C140, 32'h00032C0A, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    clr_pulse();

    frame(16'd8, 32'h0003C140, 32'h00032C0A, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    frame(16'd9, 32'h00011111, 32'h00032C0A, 32'h00012345, 1'b0, 1'b0, 1'b0, 1'b0);

    force dut.r_frame_cnt = 16'hFFFF;
    tick();
    release dut.r_frame_cnt;
    tick();
    chk("cnt_preset", {16'd0, frame_cnt}, 32'h0000FFFF);
    frame(16'h0000, 32'h00011111, 32'h00032C0A, 32'h00012345, 1'b0, 1'b0, 1'b0, 1'b0);

    wr(2'd0, 32'h00054321, 1'b1);
    wr(2'd3, 32'd0, 1'b1);
    chk("armed_pre_rst", {31'd0, armed}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_armed", {31'd0, armed}, 32'd0);
    chk("rst_mid_ball", ball_loc, 32'd0);
    chk("rst_mid_barr", barr_loc, 32'd0);
    chk("rst_mid_ready", {31'd0, wr_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", {31'd0, wr_ready}, 32'd1);
    cur_b = 32'd0; cur_l = 32'd0; cur_r = 32'd0;
    frame(16'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    tick();
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/im_frame_sync.md
Name: im_frame_sync

Overview:
- Frame-synchronous update scheduler for the Pong image memory renderer.
- CPU-side writes of ball, left-bar and right-bar locations land in pending (shadow) registers.
- On an explicit commit request, all three are copied atomically to the active registers at the next vertical-blank start, so the renderer never displays a torn frame.
- Also provides a frame counter, a per-frame vblank interrupt pulse and a sticky overrun flag. Sits between the CPU register interface and the renderer's location inputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line (informational; pixel_x unused beyond range).
- V_ACTIVE, 480, visible lines; vblank starts when pixel_y first equals V_ACTIVE.
- LOC_W, 20, stored location width: bits [9:0] = x, [19:10] = y.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pixel_x  in  10  current VGA pixel column
- pixel_y  in  10  current VGA pixel row
- wr_valid  in  1  CPU write request
- wr_ready  out  1  block accepts write this cycle
- wr_sel  in  2  0 = ball, 1 = left bar, 2 = right bar, 3 = commit request
- wr_data  in  32  location word; bits [31:20] ignored
- ball_loc  out  32  active ball location, zero-extended from LOC_W
- barl_loc  out  32  active left-bar location
- barr_loc  out  32  active right-bar location
- frame_cnt  out  16  count of vblank starts
- vblank_irq  out  1  one-cycle pulse per frame
- armed  out  1  commit pending (state ARMED or COMMIT)
- overrun  out  1  sticky: a frame passed with dirty pending data not committed
- ovr_clr  in  1  clears overrun

Behaviour:
- Reset (async, rst_n = 0):
  - state IDLE; all pending and active registers 0.
  - frame_cnt 0; vblank_irq 0; overrun 0; dirty 0; prev_y 0.
  - wr_ready reads 0 while in reset.
- Reset asserted mid-operation discards pending data and any armed commit. On release, the block resumes in IDLE.
- prev_y register holds last cycle's pixel_y. vb_edge = (pixel_y == V_ACTIVE) && (prev_y != V_ACTIVE), combinational in cycle N.
- Frame counter and interrupt:
  - On vb_edge in cycle N: frame_cnt increments at the end of N (visible N+1), wrapping 0xFFFF -> 0x0000.
  - vblank_irq = 1 in cycle N+1 only, every frame, independent of state.
- Handshake: a write transfers when wr_valid && wr_ready. wr_ready = 1 only in IDLE.
  - sel 0/1/2 in IDLE: store wr_data[19:0] into the matching pending register; set dirty.
  - sel 3 in IDLE: go to ARMED. Pending data is frozen.
- FSM states:
  - IDLE: accepts writes. On vb_edge with dirty = 1, set overrun. A sel 3 accepted in the same cycle as vb_edge goes to ARMED, does not set overrun, and commits at the following frame, not the current one.
  - ARMED: wr_ready = 0. On vb_edge, go to COMMIT.
  - COMMIT (one cycle, N+1): wr_ready = 0. At the end of N+1, copy all three pending registers to active, clear dirty, return to IDLE. New values are visible on the *_loc outputs from N+2.
- Active outputs change only on a COMMIT cycle edge or reset; they never change during the active video region.
- overrun: sticky. ovr_clr clears it. If set and clear occur in the same cycle, set wins.
- Width rules: *_loc outputs = {12'b0, active[19:0]}. Values are not range-checked.

Test Plan:
- Reset then idle for 2 frames with no writes -> *_loc = 0; frame_cnt = 2; exactly 2 vblank_irq pulses, each 1 cycle wide, one cycle after pixel_y reaches 480.
- Write ball = 0x0003C140 (y = 240, x = 320), barl = 0x00032C0A, then commit -> outputs unchanged until vb_edge cycle N; ball_loc = 0x0003C140 from N+2; armed low from N+2.
- While ARMED, drive wr_valid with sel 0 -> wr_ready = 0, pending not modified. Continue holding until IDLE -> transfer accepted, dirty set.
- Write barr with no commit across a vblank -> overrun = 1 and barr_loc unchanged. ovr_clr pulse -> overrun = 0. ovr_clr asserted on a vb_edge while dirty -> overrun remains 1.
- Commit request accepted in the same cycle as vb_edge -> no update this frame; update at the next frame's N+2; overrun stays 0.
- Preset frame_cnt to 0xFFFF via 65535 frames (or force) -> next vb_edge gives 0x0000. Assert rst_n low while ARMED -> immediately IDLE, *_loc = 0, armed = 0.
